// File: rtl/shift_issue_queue_if.sv
// Request, shifter-drive and result signals of the shift issue queue.
// The queue takes the slave side; the producer/shifter/consumer side takes master.
interface shift_issue_queue_if #(
    parameter int TAG_W = 4
);
    logic             reqValid;
    logic             reqReady;
    logic [31:0]      reqData;
    logic [4:0]       reqShamt;
    logic [1:0]       reqOp;
    logic [TAG_W-1:0] reqTag;

    logic [31:0]      shDataIn;
    logic [4:0]       shShift;
    logic             shLeft;
    logic             shArith;
    logic [31:0]      shDataOut;

    logic             resValid;
    logic             resReady;
    logic [31:0]      resData;
    logic [TAG_W-1:0] resTag;
    logic             resErr;

    modport slave (
        input  reqValid, reqData, reqShamt, reqOp, reqTag, shDataOut, resReady,
        output reqReady, shDataIn, shShift, shLeft, shArith, resValid, resData, resTag, resErr
    );

    modport master (
        output reqValid, reqData, reqShamt, reqOp, reqTag, shDataOut, resReady,
        input  reqReady, shDataIn, shShift, shLeft, shArith, resValid, resData, resTag, resErr
    );
endinterface

// File: rtl/shift_issue_queue.sv
// Issue queue in front of a combinational 32-bit barrel shifter: FIFO, opcode decode, registered result.
// Optional result counters are enabled with the SHIFT_ISSUE_STATS_EN macro.
module shift_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SHIFT_ISSUE_STATS_EN
    output logic [31:0]         statCount,
    output logic [15:0]         statErrCount,
`endif
    shift_issue_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_RSVD = 2'b10,
        OP_SRA  = 2'b11
    } op_e;

    logic [31:0]      mem_data  [DEPTH];
    logic [4:0]       mem_shamt [DEPTH];
    op_e              mem_op    [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             enq;
    logic             deq;
    op_e              head_op;

    logic             res_valid;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign enq     = bus.reqValid && !full;
    assign deq     = !empty && (!res_valid || bus.resReady);
    assign head_op = mem_op[rd_ptr[AW-1:0]];

    assign bus.reqReady = !full;
    assign bus.resValid = res_valid;
    assign bus.resData  = res_data;
    assign bus.resTag   = res_tag;
    assign bus.resErr   = res_err;

    // Shifter is driven straight from the head entry; an empty queue presents all zeros.
    always_comb begin
        bus.shDataIn = '0;
        bus.shShift  = '0;
        bus.shLeft   = 1'b0;
        bus.shArith  = 1'b0;
        if (!empty) begin
            bus.shDataIn = mem_data[rd_ptr[AW-1:0]];
            bus.shShift  = mem_shamt[rd_ptr[AW-1:0]];
            bus.shLeft   = (head_op == OP_SLL);
            bus.shArith  = (head_op == OP_SRA);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_data[wr_ptr[AW-1:0]]  <= bus.reqData;
            mem_shamt[wr_ptr[AW-1:0]] <= bus.reqShamt;
            mem_op[wr_ptr[AW-1:0]]    <= op_e'(bus.reqOp);
            mem_tag[wr_ptr[AW-1:0]]   <= bus.reqTag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else if (deq) begin
            res_valid <= 1'b1;
            res_data  <= (head_op == OP_RSVD) ? '0 : bus.shDataOut;
            res_tag   <= mem_tag[rd_ptr[AW-1:0]];
            res_err   <= (head_op == OP_RSVD);
        end else if (res_valid && bus.resReady) begin
            res_valid <= 1'b0;
        end
    end

`ifdef SHIFT_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            statCount    <= '0;
            statErrCount <= '0;
        end else if (res_valid && bus.resReady) begin
            statCount <= statCount + 32'd1;
            if (res_err && (statErrCount != 16'hFFFF))
                statErrCount <= statErrCount + 16'd1;
        end
    end
`endif
endmodule

// File: doc/shift_issue_queue.md
Name: shift_issue_queue

Overview:
- Upstream issue/buffer stage for the 32-bit barrel shifter.
- Accepts shift requests over a valid/ready handshake and buffers them in a small FIFO.
- Decodes the opcode into the shifter's direction and arithmetic controls, drives the shifter combinationally from the FIFO head, and registers the shifter result into a valid/ready output stage with a tag.
- Lets the combinational shifter sit in a pipelined execute path without stalling the producer on every cycle.

Parameters:
- DEPTH, 4, FIFO entries. Power of 2, minimum 2.
- TAG_W, 4, width of the opaque request tag returned with the result.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- reqValid  input  1  request valid
- reqReady  output  1  queue can accept a request; equals !full
- reqData  input  32  operand to shift
- reqShamt  input  5  shift amount
- reqOp  input  2  opcode: 00 SLL, 01 SRL, 11 SRA, 10 reserved
- reqTag  input  TAG_W  request tag
- shDataIn  output  32  to shifter dataIn
- shShift  output  5  to shifter shift
- shLeft  output  1  to shifter shiftLeft
- shArith  output  1  to shifter arithmetic
- shDataOut  input  32  from shifter dataOut (combinational return)
- resValid  output  1  result valid
- resReady  input  1  consumer accepts result
- resData  output  32  registered shift result
- resTag  output  TAG_W  tag of the result
- resErr  output  1  reserved opcode was issued

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - On reset: FIFO empty, pointers 0, reqReady=1, resValid=0, resData=0, resTag=0, resErr=0.
  - Reset asserted mid-operation discards all queued and in-flight requests. No result is produced for them.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits with wrap bit.
  - Empty when pointers are equal. Full when the index bits are equal and the wrap bits differ.
  - Enqueue when reqValid && reqReady.
  - reqReady = !full. There is no same-cycle enqueue-into-full, even if a dequeue occurs that cycle.
  - Simultaneous enqueue and dequeue on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo 2*DEPTH.
- Shifter drive (combinational, from FIFO head):
  - shDataIn = head.data, shShift = head.shamt.
  - shLeft = (op==00).
  - shArith = (op==11).
  - When the FIFO is empty, all sh* outputs are 0.
- Issue: when !empty && (!resValid || resReady) at a clock edge:
  - pop the head;
  - resData <= shDataOut, except resData <= 0 for op 10;
  - resTag <= head.tag;
  - resErr <= (op==10);
  - resValid <= 1.
- Output stage:
  - Otherwise, if resValid && resReady, then resValid <= 0 and the data/tag/err registers hold their values.
  - Output is stable while resValid && !resReady.
- Latency:
  - A request accepted at edge E appears with resValid=1 after edge E+1, provided the output stage is free.
  - Throughput is 1 result/cycle with resReady held high.
- Ordering: results are returned strictly in request order.
- Backpressure: with resReady low, the FIFO fills to DEPTH entries, plus 1 held in the output register, then reqReady drops.

Optional Feature:
- Macro: SHIFT_ISSUE_STATS_EN.
- When defined:
  - Adds output port statCount (32 bits).
  - Increments on every result handshake (resValid && resReady).
  - Wraps at 2^32 and resets to 0.
  - Adds output port statErrCount (16 bits).
  - Increments on each handshake with resErr=1.
  - Saturates at 16'hFFFF.
- When undefined: neither port nor any counter logic exists.

Test Plan:
- Reset, then a single SLL: data=32'h0000_0001, shamt=4, tag=3, resReady=1 -> resValid one cycle after acceptance, resData=32'h0000_0010, resTag=3, resErr=0.
- SRA: data=32'h8000_0000, shamt=31 -> resData=32'hFFFF_FFFF. SRL with the same values -> resData=32'h0000_0001. Check shArith/shLeft levels while each request is at the head.
- Hold resReady=0 and send DEPTH+2 requests -> exactly DEPTH+1 accepted, reqReady=0 thereafter. Release resReady -> all results drain in tag order 0..DEPTH, one per cycle.
- Reserved op 10: data=32'h1234_5678 -> resErr=1, resData=0. Next request SLL, shamt=0 -> resErr=0, resData equals the input.
- Assert rst for one cycle with 3 queued requests and resValid=1 -> next cycle resValid=0, reqReady=1. Subsequent request results are correct, and no stale tags appear.
- With SHIFT_ISSUE_STATS_EN defined: complete 5 handshakes including 1 reserved op -> statCount=5, statErrCount=1. A stall with resReady=0 does not count.
